// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state encoding and BCD constants for the stopwatch controller.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVF   = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic digit_at_max(input logic [3:0] d);
        return d == BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// rtl/bcd_stopwatch_ctrl_if.sv - control requests and count/status outputs of the stopwatch.
interface bcd_stopwatch_ctrl_if #(
    parameter int DIGITS = 4
);

    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  lap;
    logic [4*DIGITS-1:0]   count;
    logic [4*DIGITS-1:0]   lap_count;
    logic                  lap_valid;
    logic                  running;
    logic                  overflow;

    modport master (
        output start,
        output stop,
        output clear,
        output lap,
        input  count,
        input  lap_count,
        input  lap_valid,
        input  running,
        input  overflow
    );

    modport slave (
        input  start,
        input  stop,
        input  clear,
        input  lap,
        output count,
        output lap_count,
        output lap_valid,
        output running,
        output overflow
    );

endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one decimal digit 0..9 with synchronous clear and ripple carry out.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clr) begin
            digit_d = 4'd0;
        end else if (inc) begin
            digit_d = digit_at_max(digit_q) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    // Carry is combinational so the next digit steps on the same edge.
    assign carry = inc & digit_at_max(digit_q);

endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// rtl/bcd_stopwatch_ctrl.sv - run/pause/overflow stopwatch: prescaler, cascaded BCD digits, lap snapshot.
module bcd_stopwatch_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_stopwatch_ctrl_if.slave  sw
);

    localparam int             PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

    state_e                state_q;
    state_e                state_d;
    logic [PW-1:0]         presc_q;
    logic [PW-1:0]         presc_d;
    logic [4*DIGITS-1:0]   lap_count_q;
    logic [4*DIGITS-1:0]   lap_count_d;
    logic                  lap_valid_q;
    logic                  lap_valid_d;

    logic [4*DIGITS-1:0]   count_w;
    logic [DIGITS:0]       inc_w;
    logic                  tick;
    logic                  all_max;

    always_comb begin
        all_max = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!digit_at_max(count_w[4*i +: 4])) begin
                all_max = 1'b0;
            end
        end
    end

    assign tick     = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    // A tick at all-9s saturates instead of wrapping; clear always wins.
    assign inc_w[0] = tick && !sw.clear && !all_max;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (sw.clear),
            .inc   (inc_w[i]),
            .digit (count_w[4*i +: 4]),
            .carry (inc_w[i+1])
        );
    end

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        lap_count_d = lap_count_q;
        lap_valid_d = 1'b0;
        if (sw.clear) begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            lap_count_d = '0;
        end else begin
            if (sw.lap && (state_q != ST_IDLE)) begin
                lap_count_d = count_w;
                lap_valid_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (sw.start && !sw.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    if (tick && all_max) begin
                        state_d = ST_OVF;
                    end else if (sw.stop) begin
                        state_d = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (sw.start && !sw.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_OVF: begin
                    state_d = ST_OVF;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            lap_count_q <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lap_count_q <= lap_count_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    // The top digit's carry can never fire because increments stop at all-9s.
    assert property (@(posedge clk) disable iff (rst) !inc_w[DIGITS]);

    assign sw.count     = count_w;
    assign sw.lap_count = lap_count_q;
    assign sw.lap_valid = lap_valid_q;
    assign sw.running   = (state_q == ST_RUN);
    assign sw.overflow  = (state_q == ST_OVF);

endmodule

// File: tb/tb_bcd_stopwatch_ctrl.sv
// tb/tb_bcd_stopwatch_ctrl.sv - directed scenarios plus random stimulus against an integer stopwatch model.
module tb_bcd_stopwatch_ctrl;

    localparam int DIGITS   = 2;
    localparam int TICK_DIV = 4;
    localparam int MAX_VAL  = 99;
    localparam int M_IDLE   = 0;
    localparam int M_RUN    = 1;
    localparam int M_PAUSE  = 2;
    localparam int M_OVF    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bcd_stopwatch_ctrl_if #(.DIGITS(DIGITS)) sw_if ();

    bcd_stopwatch_ctrl #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit done     = 1'b0;

    int m_mode = M_IDLE;
    int m_val  = 0;
    int m_ph   = 0;
    int m_lap  = 0;
    bit m_lapv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r;
        int rem;
        r = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    // Elapsed time kept as a plain integer of ticks; phase counts cycles within a tick.
    task automatic model_step();
        int  nxt;
        bit  tick;
        if (rst || sw_if.clear) begin
            m_mode = M_IDLE;
            m_val  = 0;
            m_ph   = 0;
            m_lap  = 0;
            m_lapv = 1'b0;
            return;
        end
        m_lapv = sw_if.lap && (m_mode != M_IDLE);
        if (m_lapv) m_lap = m_val;
        nxt = m_mode;
        case (m_mode)
            M_IDLE, M_PAUSE: begin
                if (sw_if.start && !sw_if.stop) nxt = M_RUN;
            end
            M_RUN: begin
                tick = (m_ph == TICK_DIV - 1);
                m_ph = tick ? 0 : m_ph + 1;
                if (sw_if.stop) nxt = M_PAUSE;
                if (tick) begin
                    if (m_val == MAX_VAL) nxt = M_OVF;
                    else m_val++;
                end
            end
            default: ;
        endcase
        m_mode = nxt;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            if (!done) begin
                check("model count", 32'(sw_if.count), 32'(to_bcd(m_val)));
                check("model lap_count", 32'(sw_if.lap_count), 32'(to_bcd(m_lap)));
                check("model lap_valid", 32'(sw_if.lap_valid), 32'(m_lapv));
                check("model running", 32'(sw_if.running), 32'(m_mode == M_RUN));
                check("model overflow", 32'(sw_if.overflow), 32'(m_mode == M_OVF));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear();
        sw_if.clear = 1'b1;
        step(1);
        sw_if.clear = 1'b0;
    endtask

    task automatic pulse_start();
        sw_if.start = 1'b1;
        step(1);
        sw_if.start = 1'b0;
    endtask

    initial begin
        sw_if.start = 1'b0;
        sw_if.stop  = 1'b0;
        sw_if.clear = 1'b0;
        sw_if.lap   = 1'b0;
        step(3);
        check("reset count", 32'(sw_if.count), 32'h0);
        check("reset running", 32'(sw_if.running), 32'h0);
        check("reset overflow", 32'(sw_if.overflow), 32'h0);
        check("reset lap_valid", 32'(sw_if.lap_valid), 32'h0);
        rst = 1'b0;
        step(2);

        // 40 cycles of run: digit 0 rolls 9 -> 0 as digit 1 goes 0 -> 1
        pulse_start();
        step(39);
        check("run39 count", 32'(sw_if.count), 32'h09);
        step(1);
        check("run40 count", 32'(sw_if.count), 32'h10);
        check("run40 running", 32'(sw_if.running), 32'h1);
        pulse_clear();

        // Pause keeps the sub-tick phase
        pulse_start();
        step(5);
        sw_if.stop = 1'b1;
        step(1);
        sw_if.stop = 1'b0;
        step(10);
        check("pause count", 32'(sw_if.count), 32'h01);
        check("pause running", 32'(sw_if.running), 32'h0);
        pulse_start();
        check("resume running", 32'(sw_if.running), 32'h1);
        step(1);
        check("resume+1 count", 32'(sw_if.count), 32'h01);
        step(1);
        check("resume+2 count", 32'(sw_if.count), 32'h02);
        pulse_clear();

        // Saturate at 99 and enter overflow
        pulse_start();
        step(396);
        check("at99 count", 32'(sw_if.count), 32'h99);
        check("at99 overflow", 32'(sw_if.overflow), 32'h0);
        step(4);
        check("ovf count", 32'(sw_if.count), 32'h99);
        check("ovf overflow", 32'(sw_if.overflow), 32'h1);
        check("ovf running", 32'(sw_if.running), 32'h0);
        sw_if.start = 1'b1;
        step(3);
        sw_if.start = 1'b0;
        check("ovf start ignored", 32'(sw_if.overflow), 32'h1);
        sw_if.lap = 1'b1;
        step(1);
        sw_if.lap = 1'b0;
        check("ovf lap_valid", 32'(sw_if.lap_valid), 32'h1);
        check("ovf lap_count", 32'(sw_if.lap_count), 32'h99);
        pulse_clear();
        check("ovf clear count", 32'(sw_if.count), 32'h0);
        check("ovf clear overflow", 32'(sw_if.overflow), 32'h0);
        check("ovf clear lap_count", 32'(sw_if.lap_count), 32'h0);

        // Lap on the tick edge captures the pre-increment value
        pulse_start();
        step(95);
        check("prelap count", 32'(sw_if.count), 32'h23);
        sw_if.lap = 1'b1;
        step(1);
        sw_if.lap = 1'b0;
        check("lap lap_count", 32'(sw_if.lap_count), 32'h23);
        check("lap lap_valid", 32'(sw_if.lap_valid), 32'h1);
        check("lap count", 32'(sw_if.count), 32'h24);
        step(1);
        check("lap pulse end", 32'(sw_if.lap_valid), 32'h0);
        sw_if.clear = 1'b1;
        sw_if.lap   = 1'b1;
        step(1);
        sw_if.clear = 1'b0;
        sw_if.lap   = 1'b0;
        check("clear+lap count", 32'(sw_if.count), 32'h0);
        check("clear+lap lap_valid", 32'(sw_if.lap_valid), 32'h0);
        check("clear+lap running", 32'(sw_if.running), 32'h0);

        // start and stop together in IDLE
        sw_if.start = 1'b1;
        sw_if.stop  = 1'b1;
        step(1);
        sw_if.start = 1'b0;
        sw_if.stop  = 1'b0;
        check("start+stop idle running", 32'(sw_if.running), 32'h0);
        step(8);
        check("start+stop idle count", 32'(sw_if.count), 32'h0);

        // Asynchronous reset mid-run
        pulse_start();
        step(228);
        check("prerst count", 32'(sw_if.count), 32'h57);
        #2 rst = 1'b1;
        #1;
        check("async rst count", 32'(sw_if.count), 32'h0);
        check("async rst running", 32'(sw_if.running), 32'h0);
        check("async rst lap_valid", 32'(sw_if.lap_valid), 32'h0);
        check("async rst overflow", 32'(sw_if.overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(20);
        check("post rst count", 32'(sw_if.count), 32'h0);
        check("post rst running", 32'(sw_if.running), 32'h0);
        pulse_start();
        check("post rst start", 32'(sw_if.running), 32'h1);

        // Random control traffic
        for (int i = 0; i < 1200; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            sw_if.start = ($urandom_range(0, 4) == 0);
            sw_if.stop  = ($urandom_range(0, 11) == 0);
            sw_if.clear = ($urandom_range(0, 59) == 0);
            sw_if.lap   = ($urandom_range(0, 5) == 0);
            step(1);
        end
        rst         = 1'b0;
        sw_if.start = 1'b0;
        sw_if.stop  = 1'b0;
        sw_if.clear = 1'b0;
        sw_if.lap   = 1'b0;
        step(2);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
